// File: rtl/mem_port_responder_pkg.sv
// Shared command encodings, FSM states and the command record for the memory port responder.
package mem_port_responder_pkg;

  localparam logic [2:0] CMD_WRITE    = 3'b000;
  localparam logic [2:0] CMD_READ     = 3'b001;
  localparam logic [2:0] CMD_WRITE_AP = 3'b010;
  localparam logic [2:0] CMD_READ_AP  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_READ    = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } cmd_t;

  function automatic logic is_write_cmd(input logic [2:0] instr);
    return (instr == CMD_WRITE) || (instr == CMD_WRITE_AP);
  endfunction

  function automatic logic is_read_cmd(input logic [2:0] instr);
    return (instr == CMD_READ) || (instr == CMD_READ_AP);
  endfunction

endpackage

// File: rtl/mem_port_responder_if.sv
// User-port bundle: command, write-data and read-data FIFO signals between initiator and responder.
interface mem_port_responder_if;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty;
  logic        cmd_full;

  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        wr_error;

  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    input  cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    output cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );
endinterface

// File: rtl/mem_port_responder_sync_fifo.sv
// Single-clock FIFO with occupancy count. SHOW_AHEAD=1 exposes the head word combinationally;
// otherwise q is a register loaded on each accepted pop and held otherwise.
module sync_fifo #(
  parameter int W          = 32,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH + 1),
  parameter bit SHOW_AHEAD = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  q,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // Full refuses a push even if a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  generate
    if (SHOW_AHEAD) begin : g_peek
      assign q = mem[rd_ptr_reg];
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         q <= '0;
        else if (do_pop) q <= mem[rd_ptr_reg];
      end
    end
  endgenerate

endmodule

// File: rtl/mem_port_responder.sv
// Memory-port responder: services queued write/read commands against an inferred word RAM
// and returns read words through the read FIFO.
module mem_port_responder
  import mem_port_responder_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int CMD_DEPTH       = 4,
  parameter int DATA_DEPTH      = 64,
  parameter int RD_LATENCY      = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_responder_if.slave mp
);
  localparam int AW  = ADDR_WORDS_LOG2;
  localparam int LW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int CCW = $clog2(CMD_DEPTH + 1);

  cmd_t           cmd_in, cmd_head;
  logic [CCW-1:0] cmd_count;
  logic           cmd_pending, cmd_pop;
  logic [35:0]    wr_head;
  logic           wr_pop, rd_push;
  logic [AW-1:0]  addr_reg, addr_next, cmd_word_addr;
  logic [5:0]     beats_reg;
  logic [LW-1:0]  lat_reg;
  state_t         state_reg;
  logic           stalled_reg, wr_underrun_reg, wr_error_reg, rd_overflow_reg, rd_error_reg;
  logic [31:0]    ram [2**AW];
  logic [31:0]    ram_q;
  logic           unused_addr_bits;

  assign cmd_in = {mp.cmd_instr, mp.cmd_bl, mp.cmd_byte_addr};

  sync_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH), .CW(CCW), .SHOW_AHEAD(1'b1)) u_cmd_fifo (
    .clk(clk), .rst(rst), .push(mp.cmd_en), .pop(cmd_pop), .din(cmd_in), .q(cmd_head),
    .count(cmd_count), .full(mp.cmd_full), .empty(mp.cmd_empty)
  );

  sync_fifo #(.W(36), .DEPTH(DATA_DEPTH), .CW(7), .SHOW_AHEAD(1'b1)) u_wr_fifo (
    .clk(clk), .rst(rst), .push(mp.wr_en), .pop(wr_pop), .din({mp.wr_mask, mp.wr_data}),
    .q(wr_head), .count(mp.wr_count), .full(mp.wr_full), .empty(mp.wr_empty)
  );

  sync_fifo #(.W(32), .DEPTH(DATA_DEPTH), .CW(7), .SHOW_AHEAD(1'b0)) u_rd_fifo (
    .clk(clk), .rst(rst), .push(rd_push), .pop(mp.rd_en), .din(ram_q),
    .q(mp.rd_data), .count(mp.rd_count), .full(mp.rd_full), .empty(mp.rd_empty)
  );

  // Byte address bits below the word and above the RAM depth alias away.
  assign cmd_word_addr    = cmd_head.byte_addr[AW+1:2];
  assign unused_addr_bits = ^{cmd_head.byte_addr[29:AW+2], cmd_head.byte_addr[1:0]};

  assign cmd_pending = (cmd_count != '0);
  assign cmd_pop     = (state_reg == ST_IDLE) && cmd_pending;
  assign wr_pop      = (state_reg == ST_WRITE) && !mp.wr_empty;
  assign rd_push     = (state_reg == ST_READ);

  assign mp.wr_underrun = wr_underrun_reg;
  assign mp.wr_error    = wr_error_reg;
  assign mp.rd_overflow = rd_overflow_reg;
  assign mp.rd_error    = rd_error_reg;

  always_comb begin
    addr_next = addr_reg;
    if (cmd_pop)               addr_next = cmd_word_addr;
    else if (wr_pop || rd_push) addr_next = addr_reg + 1'b1;
  end

  // The RAM is read at the address the FSM holds next, so ram_q always mirrors addr_reg.
  always_ff @(posedge clk) begin
    ram_q <= ram[addr_next];
    if (wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head[32+b]) ram[addr_reg][8*b +: 8] <= wr_head[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      beats_reg       <= '0;
      lat_reg         <= '0;
      stalled_reg     <= 1'b0;
      wr_underrun_reg <= 1'b0;
      wr_error_reg    <= 1'b0;
      rd_overflow_reg <= 1'b0;
      rd_error_reg    <= 1'b0;
    end else begin
      wr_underrun_reg <= 1'b0;
      rd_overflow_reg <= 1'b0;
      addr_reg        <= addr_next;
      if (mp.wr_en && mp.wr_full) wr_error_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_pending) begin
            beats_reg <= cmd_head.bl;
            lat_reg   <= LW'(RD_LATENCY - 1);
            if (is_write_cmd(cmd_head.instr))
              state_reg <= ST_WRITE;
            else if (is_read_cmd(cmd_head.instr))
              state_reg <= (RD_LATENCY == 1) ? ST_READ : ST_RD_WAIT;
          end
        end
        ST_WRITE: begin
          if (!mp.wr_empty) begin
            stalled_reg <= 1'b0;
            if (beats_reg == '0) state_reg <= ST_IDLE;
            else                 beats_reg <= beats_reg - 1'b1;
          end else begin
            stalled_reg     <= 1'b1;
            wr_underrun_reg <= !stalled_reg;
            wr_error_reg    <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          lat_reg <= lat_reg - 1'b1;
          if (lat_reg == LW'(1)) state_reg <= ST_READ;
        end
        ST_READ: begin
          if (mp.rd_full) begin
            rd_overflow_reg <= 1'b1;
            rd_error_reg    <= 1'b1;
          end
          if (beats_reg == '0) state_reg <= ST_IDLE;
          else                 beats_reg <= beats_reg - 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
